// File: rtl/cksum_ctrl.sv
// cksum_ctrl: streaming 8-bit one's complement checksum engine.
// Accepts a byte stream per packet, then presents sum/cksum/len/err.
module cksum_ctrl #(
    parameter int unsigned MAX_BYTES = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_sum,
    output logic [7:0] out_cksum,
    output logic [7:0] out_len,
    output logic       out_err
);

    localparam logic [7:0] LP_MAX = 8'(MAX_BYTES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t     r_state;
    logic [7:0] r_acc;
    logic [7:0] r_cnt;
    logic       r_err;

    state_t     w_nxt_state;
    logic [7:0] w_nxt_acc;
    logic [7:0] w_nxt_cnt;
    logic       w_nxt_err;
    logic [8:0] w_sum9;
    logic [7:0] w_add;
    logic       w_full;

    // End-around carry add of the incoming byte into the accumulator
    always_comb begin
        w_sum9 = {1'b0, r_acc} + {1'b0, in_data};
        w_add  = w_sum9[7:0] + {7'd0, w_sum9[8]};
        w_full = (r_cnt == LP_MAX);
    end

    // Next-state and handshake outputs
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_acc   = r_acc;
        w_nxt_cnt   = r_cnt;
        w_nxt_err   = r_err;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_nxt_acc   = in_data;
                    w_nxt_cnt   = 8'd1;
                    w_nxt_err   = 1'b0;
                    w_nxt_state = in_last ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_nxt_acc = w_add;
                    w_nxt_cnt = w_full ? r_cnt : r_cnt + 8'd1;
                    w_nxt_err = r_err | w_full;
                    if (in_last) begin
                        w_nxt_state = S_DONE;
                    end
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_acc   = 8'h00;
                    w_nxt_cnt   = 8'd0;
                    w_nxt_err   = 1'b0;
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_acc   = 8'h00;
                w_nxt_cnt   = 8'd0;
                w_nxt_err   = 1'b0;
            end
        endcase
    end

    // State and datapath registers, reset has priority over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_acc   <= 8'h00;
            r_cnt   <= 8'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_acc   <= w_nxt_acc;
            r_cnt   <= w_nxt_cnt;
            r_err   <= w_nxt_err;
        end
    end

    // Result fields mirror the registers; zero in IDLE
    always_comb begin
        out_sum   = r_acc;
        out_cksum = ~r_acc;
        out_len   = r_cnt;
        out_err   = r_err;
    end

endmodule

// File: tb/tb_cksum_ctrl.sv
// tb_cksum_ctrl: directed stimulus with an integer-arithmetic
// reference model compared every cycle, plus literal result checks.
module tb_cksum_ctrl;

    localparam int MAXB = 4;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_sum;
    logic [7:0] out_cksum;
    logic [7:0] out_len;
    logic       out_err;

    int n_checks = 0;
    int n_errs   = 0;

    cksum_ctrl #(.MAX_BYTES(MAXB)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_sum  (out_sum),
        .out_cksum(out_cksum),
        .out_len  (out_len),
        .out_err  (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: packet total as a plain integer, byte count,
    // and a flag saying a result is being presented.
    int         m_tot  = 0;
    int         m_n    = 0;
    logic       m_done = 1'b0;
    logic [7:0] m_sum  = 8'h00;
    logic [7:0] m_len  = 8'h00;
    logic       m_err  = 1'b0;

    function automatic logic [7:0] oc_sum(input int tot);
        if (tot == 0) return 8'h00;
        return 8'((tot - 1) % 255 + 1);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_tot  <= 0;
            m_n    <= 0;
            m_done <= 1'b0;
        end else if (m_done) begin
            if (out_ready) begin
                m_done <= 1'b0;
                m_tot  <= 0;
                m_n    <= 0;
            end
        end else if (in_valid) begin
            if (in_last) begin
                m_done <= 1'b1;
                m_sum  <= oc_sum(m_tot + int'(in_data));
                m_len  <= 8'((m_n + 1 > MAXB) ? MAXB : m_n + 1);
                m_err  <= (m_n + 1 > MAXB);
                m_tot  <= 0;
                m_n    <= 0;
            end else begin
                m_tot <= m_tot + int'(in_data);
                m_n   <= m_n + 1;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("m_in_ready", {7'd0, in_ready}, {7'd0, !m_done});
        chk("m_out_valid", {7'd0, out_valid}, {7'd0, m_done});
        if (m_done) begin
            chk("m_sum", out_sum, m_sum);
            chk("m_cksum", out_cksum, ~m_sum);
            chk("m_len", out_len, m_len);
            chk("m_err", {7'd0, out_err}, {7'd0, m_err});
        end else if (m_n == 0) begin
            chk("m_idle_sum", out_sum, 8'h00);
            chk("m_idle_cksum", out_cksum, 8'hFF);
            chk("m_idle_len", out_len, 8'h00);
            chk("m_idle_err", {7'd0, out_err}, 8'h00);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input logic [7:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        idle(1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic expect_res(input logic [7:0] s, input logic [7:0] ck,
                              input logic [7:0] len, input logic err,
                              input int hold);
        chk("lat_valid", {7'd0, out_valid}, 8'h01);
        chk("lit_sum", out_sum, s);
        chk("lit_cksum", out_cksum, ck);
        chk("lit_len", out_len, len);
        chk("lit_err", {7'd0, out_err}, {7'd0, err});
        chk("done_in_ready", {7'd0, in_ready}, 8'h00);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h77;
            in_last  = 1'b1;
            idle(1);
            chk("hold_valid", {7'd0, out_valid}, 8'h01);
            chk("hold_sum", out_sum, s);
            chk("hold_len", out_len, len);
            chk("hold_in_ready", {7'd0, in_ready}, 8'h00);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        chk("post_valid", {7'd0, out_valid}, 8'h00);
        chk("post_in_ready", {7'd0, in_ready}, 8'h01);
        chk("post_sum", out_sum, 8'h00);
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        idle(3);
        chk("rst_cksum", out_cksum, 8'hFF);
        chk("rst_in_ready", {7'd0, in_ready}, 8'h01);
        rst = 1'b0;
        idle(1);

        beat(8'h1F, 1'b0);
        beat(8'hF0, 1'b1);
        expect_res(8'h10, 8'hEF, 8'd2, 1'b0, 0);

        beat(8'hAB, 1'b0);
        beat(8'hCD, 1'b1);
        expect_res(8'h79, 8'h86, 8'd2, 1'b0, 0);

        beat(8'hFF, 1'b0);
        beat(8'hFF, 1'b1);
        expect_res(8'hFF, 8'h00, 8'd2, 1'b0, 0);

        beat(8'h01, 1'b0);
        idle(2);
        beat(8'h10, 1'b0);
        idle(2);
        beat(8'hF0, 1'b1);
        expect_res(8'h02, 8'hFD, 8'd3, 1'b0, 0);

        in_last = 1'b1;
        idle(1);
        in_last = 1'b0;
        beat(8'h00, 1'b1);
        expect_res(8'h00, 8'hFF, 8'd1, 1'b0, 5);

        for (int i = 0; i < 4; i++) beat(8'h01, 1'b0);
        beat(8'h01, 1'b1);
        expect_res(8'h05, 8'hFA, 8'd4, 1'b1, 0);
        beat(8'h1F, 1'b0);
        beat(8'hF0, 1'b1);
        expect_res(8'h10, 8'hEF, 8'd2, 1'b0, 0);

        beat(8'h12, 1'b0);
        beat(8'h34, 1'b0);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h99;
        in_last  = 1'b1;
        idle(1);
        rst      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("abort_valid", {7'd0, out_valid}, 8'h00);
        chk("abort_len", out_len, 8'h00);
        beat(8'h56, 1'b1);
        expect_res(8'h56, 8'hA9, 8'd1, 1'b0, 0);

        beat(8'hAA, 1'b1);
        chk("done_valid", {7'd0, out_valid}, 8'h01);
        rst       = 1'b1;
        out_ready = 1'b1;
        idle(1);
        rst       = 1'b0;
        out_ready = 1'b0;
        chk("rst_done_valid", {7'd0, out_valid}, 8'h00);
        chk("rst_done_sum", out_sum, 8'h00);
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/cksum_ctrl.md
CKSUM_CTRL -- requirements
Module: cksum_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_BYTES, default 255, meaning the maximum accepted packet length in bytes (range 1..255).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-high reset, sampled on the clk rising edge.
REQ-004 The block SHALL have port in_data  input  8  packet byte.
REQ-005 The block SHALL have port in_valid  input  1  in_data/in_last valid this cycle.
REQ-006 The block SHALL have port in_last  input  1  current byte is the final byte of the packet.
REQ-007 The block SHALL have port in_ready  output  1  block accepts a byte this cycle.
REQ-008 The block SHALL have port out_ready  input  1  consumer accepts the result.
REQ-009 The block SHALL have port out_valid  output  1  result fields valid.
REQ-010 The block SHALL have port out_sum  output  8  one's complement sum of the packet bytes.
REQ-011 The block SHALL have port out_cksum  output  8  bitwise inverse of out_sum.
REQ-012 The block SHALL have port out_len  output  8  count of accepted bytes, saturating at MAX_BYTES.
REQ-013 The block SHALL have port out_err  output  1  packet exceeded MAX_BYTES.

Function
REQ-014 A beat SHALL be accepted only in a cycle where in_valid && in_ready; no other cycle changes the accumulator.
REQ-015 The addition SHALL be 8-bit one's complement: 9-bit sum of accumulator and in_data, carry-out added back into bit 0 (end-around carry) in the same cycle.
REQ-016 The FSM SHALL have states IDLE, ACCUM, DONE.
REQ-017 IDLE: in_ready=1, out_valid=0, accumulator=0x00, count=0, err=0.
REQ-018 IDLE, beat accepted: accumulator <= in_data, count <= 1; go to DONE if in_last, else ACCUM.
REQ-019 ACCUM: in_ready=1, out_valid=0; a beat updates accumulator <= accumulator (+1c) in_data and increments count; go to DONE on in_last, stay otherwise; no beat -> hold all state.
REQ-020 A beat accepted while count == MAX_BYTES SHALL set err (sticky until IDLE), still be summed, and leave count at MAX_BYTES.
REQ-021 DONE: in_ready=0, out_valid=1; out_sum=accumulator, out_cksum=~accumulator, out_len=count, out_err=err, all stable while out_ready=0.
REQ-022 DONE with out_ready=1: return to IDLE next cycle, clearing accumulator, count and err.
REQ-023 Latency: out_valid SHALL rise exactly one cycle after the clock edge accepting the in_last beat.
REQ-024 Throughput: one byte per cycle in IDLE/ACCUM; a new packet's first byte is accepted no earlier than the cycle after the result handshake (one bubble minimum).
REQ-025 in_valid while in_ready=0 SHALL be ignored; in_last outside an accepted beat SHALL have no effect.
REQ-026 The all-ones result 0xFF (negative zero) SHALL be reported as 0xFF, never normalised to 0x00.

Reset
REQ-027 rst=1 at a clock edge SHALL force state IDLE, accumulator 0x00, count 0, err 0, from any state including mid-packet and DONE.
REQ-028 During and after reset: in_ready=1, out_valid=0, out_sum=0x00, out_cksum=0xFF, out_len=0x00, out_err=0.
REQ-029 rst SHALL take priority over any simultaneous beat or result handshake; a packet interrupted by reset SHALL produce no result.

Verification
REQ-030 Bytes 0x1F, 0xF0(last), out_ready=1 -> one cycle later out_valid=1, out_sum=0x10, out_cksum=0xEF, out_len=2, out_err=0.
REQ-031 Bytes 0xAB, 0xCD(last) -> out_sum=0x79, out_cksum=0x86; bytes 0xFF, 0xFF(last) -> out_sum=0xFF, out_cksum=0x00.
REQ-032 Bytes 0x01, 0x10, 0xF0(last) with in_valid deasserted two cycles between bytes -> out_sum=0x02, out_cksum=0xFD, out_len=3.
REQ-033 Single byte 0x00(last), out_ready held 0 for 5 cycles -> out_valid=1, out_sum=0x00, out_cksum=0xFF, out_len=1 held stable, in_ready=0 throughout; IDLE the cycle after out_ready=1.
REQ-034 MAX_BYTES=4, bytes 0x01 x5 (fifth last) -> out_sum=0x05, out_len=4, out_err=1; the next packet reports out_err=0.
REQ-035 rst=1 for one cycle after bytes 0x12, 0x34 (no last), then byte 0x56(last) -> out_sum=0x56, out_len=1, no result for the aborted packet.
